// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRP_DEF   = 2;
  localparam int NWP_DEF   = 1;
  localparam int NWP_MAX   = 4;

  // Address width that never collapses to zero bits, even for tiny files.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a flattened multi-port bus: one field of fieldW bits per port.
  function automatic int busWidth(input int nPorts, input int fieldW);
    return nPorts * fieldW;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue and cleared by writeback.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWP   = NWP_DEF,
  localparam int AW   = clog2_safe(NREGS)
) (
  input  logic                          Clk,
  input  logic                          reset,
  input  logic [NWP-1:0]                WEn,
  input  logic [busWidth(NWP, AW)-1:0]  AddrW,
  input  logic                          IssueEn,
  input  logic [AW-1:0]                 IssueAddr,
  output logic [NREGS-1:0]              busy
);

  logic [NREGS-1:0] busyNext;

  // Clears first, then the issue set, so a re-reserved destination stays busy.
  always_comb begin
    busyNext = busy;
    for (int j = 0; j < NWP; j++) begin
      if (WEn[j]) begin
        busyNext[AddrW[j*AW +: AW]] = 1'b0;
      end
    end
    if (IssueEn && (IssueAddr != '0)) begin
      busyNext[IssueAddr] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised NRP-read / NWP-write integer register file with optional write-to-read
// bypass and a per-register pending-write scoreboard.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRP    = NRP_DEF,
  parameter int NWP    = NWP_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = clog2_safe(NREGS)
) (
  input  logic                            Clk,
  input  logic                            reset,
  input  logic [busWidth(NRP, AW)-1:0]    AddrR,
  output logic [busWidth(NRP, XLEN)-1:0]  DataR,
  output logic [NRP-1:0]                  BusyR,
  input  logic [NWP-1:0]                  WEn,
  input  logic [busWidth(NWP, AW)-1:0]    AddrW,
  input  logic [busWidth(NWP, XLEN)-1:0]  DataW,
  input  logic                            IssueEn,
  input  logic [AW-1:0]                   IssueAddr
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  // Ports are walked in ascending order, so the highest-index port's update lands last.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (WEn[j] && (AddrW[j*AW +: AW] != '0)) begin
          regs[AddrW[j*AW +: AW]] <= DataW[j*XLEN +: XLEN];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWP   (NWP)
  ) uScoreboard (
    .Clk       (Clk),
    .reset     (reset),
    .WEn       (WEn),
    .AddrW     (AddrW),
    .IssueEn   (IssueEn),
    .IssueAddr (IssueAddr),
    .busy      (busy)
  );

  for (genvar i = 0; i < NRP; i++) begin : gRead
    logic [AW-1:0]   rdAddr;
    logic [XLEN-1:0] rdData;
    logic            rdBusy;

    assign rdAddr = AddrR[i*AW +: AW];

    // Bypass compares run in parallel with the array read; later ports override earlier.
    always_comb begin
      rdData = regs[rdAddr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWP; j++) begin
          if (WEn[j] && (AddrW[j*AW +: AW] == rdAddr)) begin
            rdData = DataW[j*XLEN +: XLEN];
          end
        end
      end
      if (reset || (rdAddr == '0)) begin
        rdData = '0;
      end
    end

    assign rdBusy = busy[rdAddr] & ~reset;

    assign DataR[i*XLEN +: XLEN] = rdData;
    assign BusyR[i]              = rdBusy;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed and randomised self-checking bench for register_file_mp.
module tb_register_file_mp;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Shared stimulus for instances A (bypass) and B (no bypass): NRP=2, NWP=2, 32x32.
  logic [9:0]  abAddrR;
  logic [1:0]  abWEn;
  logic [9:0]  abAddrW;
  logic [63:0] abDataW;
  logic        abIss;
  logic [4:0]  abIssAddr;
  logic [63:0] aDataR, bDataR;
  logic [1:0]  aBusyR, bBusyR;

  // Instance C: XLEN=64, NREGS=16, NRP=4, NWP=2, bypass on.
  logic [15:0]  cAddrR;
  logic [1:0]   cWEn;
  logic [7:0]   cAddrW;
  logic [127:0] cDataW;
  logic         cIss;
  logic [3:0]   cIssAddr;
  logic [255:0] cDataR;
  logic [3:0]   cBusyR;

  register_file_mp #(.XLEN(32), .NREGS(32), .NRP(2), .NWP(2), .BYPASS(1)) dutA (
    .Clk(Clk), .reset(reset), .AddrR(abAddrR), .DataR(aDataR), .BusyR(aBusyR),
    .WEn(abWEn), .AddrW(abAddrW), .DataW(abDataW), .IssueEn(abIss), .IssueAddr(abIssAddr));

  register_file_mp #(.XLEN(32), .NREGS(32), .NRP(2), .NWP(2), .BYPASS(0)) dutB (
    .Clk(Clk), .reset(reset), .AddrR(abAddrR), .DataR(bDataR), .BusyR(bBusyR),
    .WEn(abWEn), .AddrW(abAddrW), .DataW(abDataW), .IssueEn(abIss), .IssueAddr(abIssAddr));

  register_file_mp #(.XLEN(64), .NREGS(16), .NRP(4), .NWP(2), .BYPASS(1)) dutC (
    .Clk(Clk), .reset(reset), .AddrR(cAddrR), .DataR(cDataR), .BusyR(cBusyR),
    .WEn(cWEn), .AddrW(cAddrW), .DataW(cDataW), .IssueEn(cIss), .IssueAddr(cIssAddr));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkAB(input string name, input logic [31:0] eA0, input logic [31:0] eA1,
                       input logic [31:0] eB0, input logic [31:0] eB1, input logic [1:0] eBusy);
    chk({name, " A.DataR0"}, 64'(aDataR[31:0]), 64'(eA0));
    chk({name, " A.DataR1"}, 64'(aDataR[63:32]), 64'(eA1));
    chk({name, " B.DataR0"}, 64'(bDataR[31:0]), 64'(eB0));
    chk({name, " B.DataR1"}, 64'(bDataR[63:32]), 64'(eB1));
    chk({name, " A.BusyR"}, 64'(aBusyR), 64'(eBusy));
    chk({name, " B.BusyR"}, 64'(bBusyR), 64'(eBusy));
  endtask

  task automatic driveAB(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] wen,
                         input logic [4:0] w0, input logic [4:0] w1, input logic [31:0] d0,
                         input logic [31:0] d1, input logic iss, input logic [4:0] ia);
    abAddrR = {r1, r0};
    abWEn = wen;
    abAddrW = {w1, w0};
    abDataW = {d1, d0};
    abIss = iss;
    abIssAddr = ia;
  endtask

  typedef struct {
    logic [4:0]  r0, r1;
    logic [1:0]  wen;
    logic [4:0]  w0, w1;
    logic [31:0] d0, d1;
    logic        iss;
    logic [4:0]  ia;
    logic [31:0] eA0, eA1, eB0, eB1;
    logic [1:0]  eBusy;
  } vec_t;

  vec_t vecs [14];

  logic [63:0] mReg [16];
  logic        mBusy [16];

  initial begin
    // r0 r1 wen w0 w1 d0 d1 iss ia | A0 A1 B0 B1 busy
    vecs[0]  = '{5, 7, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0};
    vecs[1]  = '{0, 7, 1, 7, 0, 32'h12345678, 0, 0, 0,        0, 32'h12345678, 0, 0, 0};
    vecs[2]  = '{0, 7, 0, 0, 0, 0, 0, 0, 0,                   0, 32'h12345678, 0, 32'h12345678, 0};
    vecs[3]  = '{0, 3, 3, 3, 3, 32'hA, 32'hB, 0, 0,           0, 32'hB, 0, 0, 0};
    vecs[4]  = '{0, 3, 0, 0, 0, 0, 0, 0, 0,                   0, 32'hB, 0, 32'hB, 0};
    vecs[5]  = '{0, 0, 1, 0, 0, 32'hFFFFFFFF, 0, 1, 0,        0, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0};
    vecs[7]  = '{9, 9, 0, 0, 0, 0, 0, 1, 9,                   0, 0, 0, 0, 0};
    vecs[8]  = '{9, 9, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 3};
    vecs[9]  = '{9, 9, 2, 0, 9, 0, 32'h99, 0, 0,              32'h99, 32'h99, 0, 0, 3};
    vecs[10] = '{9, 9, 0, 0, 0, 0, 0, 0, 0,                   32'h99, 32'h99, 32'h99, 32'h99, 0};
    vecs[11] = '{9, 9, 1, 9, 0, 32'h55, 0, 1, 9,              32'h55, 32'h55, 32'h99, 32'h99, 0};
    vecs[12] = '{9, 9, 0, 0, 0, 0, 0, 0, 0,                   32'h55, 32'h55, 32'h55, 32'h55, 3};
    vecs[13] = '{9, 3, 0, 0, 0, 0, 0, 0, 0,                   32'h55, 32'hB, 32'h55, 32'hB, 1};

    driveAB(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cAddrR = '0; cWEn = '0; cAddrW = '0; cDataW = '0; cIss = 1'b0; cIssAddr = '0;
    for (int r = 0; r < 16; r++) begin
      mReg[r] = '0;
      mBusy[r] = 1'b0;
    end

    // Reset state, with a write attempted while reset is held.
    driveAB(5, 7, 1, 5, 0, 32'hCAFE, 0, 1, 5);
    #1;
    chkAB("reset", 0, 0, 0, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    driveAB(5, 7, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge Clk);
    chkAB("postreset", 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;

    for (int k = 0; k < 14; k++) begin
      driveAB(vecs[k].r0, vecs[k].r1, vecs[k].wen, vecs[k].w0, vecs[k].w1,
              vecs[k].d0, vecs[k].d1, vecs[k].iss, vecs[k].ia);
      @(negedge Clk);
      chkAB($sformatf("vec%0d", k), vecs[k].eA0, vecs[k].eA1, vecs[k].eB0, vecs[k].eB1, vecs[k].eBusy);
      @(posedge Clk);
      #1;
    end

    // Asynchronous reset mid-cycle after r5 is written and reserved.
    driveAB(5, 5, 1, 5, 0, 32'hDEADBEEF, 0, 1, 5);
    @(posedge Clk);
    #1;
    driveAB(5, 5, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    chkAB("r5 written", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3);
    #2;
    reset = 1'b1;
    #1;
    chkAB("async reset", 0, 0, 0, 0, 0);
    driveAB(5, 5, 1, 5, 0, 32'h1234, 0, 1, 5);
    #1;
    chkAB("reset bypass masked", 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    driveAB(5, 5, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge Clk);
    chkAB("after release", 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    driveAB(5, 5, 1, 5, 0, 32'h77, 0, 0, 0);
    @(negedge Clk);
    chkAB("first write bypass", 32'h77, 32'h77, 0, 0, 0);
    @(posedge Clk);
    #1;
    driveAB(5, 5, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    chkAB("first write array", 32'h77, 32'h77, 32'h77, 32'h77, 0);

    // Random traffic on the 64-bit / 16-register / 4-read instance against a model.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge Clk);
      for (int j = 0; j < 2; j++) begin
        if (cWEn[j] && cAddrW[j*4 +: 4] != 4'd0) begin
          mReg[cAddrW[j*4 +: 4]] = cDataW[j*64 +: 64];
        end
        if (cWEn[j]) begin
          mBusy[cAddrW[j*4 +: 4]] = 1'b0;
        end
      end
      if (cIss && cIssAddr != 4'd0) begin
        mBusy[cIssAddr] = 1'b1;
      end
      #1;
      for (int i = 0; i < 4; i++) cAddrR[i*4 +: 4] = 4'($urandom_range(0, 15));
      for (int j = 0; j < 2; j++) begin
        cAddrW[j*4 +: 4] = 4'($urandom_range(0, 15));
        cDataW[j*64 +: 64] = {$urandom, $urandom};
      end
      cWEn = 2'($urandom_range(0, 3));
      cIss = 1'($urandom_range(0, 1));
      cIssAddr = 4'($urandom_range(0, 15));
      @(negedge Clk);
      for (int i = 0; i < 4; i++) begin
        logic [3:0]  a;
        logic [63:0] v;
        a = cAddrR[i*4 +: 4];
        v = mReg[a];
        for (int j = 0; j < 2; j++) begin
          if (cWEn[j] && cAddrW[j*4 +: 4] == a) v = cDataW[j*64 +: 64];
        end
        if (a == 4'd0) v = '0;
        chk($sformatf("rand%0d DataR%0d", cyc, i), cDataR[i*64 +: 64], v);
        chk($sformatf("rand%0d BusyR%0d", cyc, i), 64'(cBusyR[i]), 64'(mBusy[a] && a != 4'd0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file with a per-register pending-write scoreboard. It sits in the decode stage of the pipelined RV32I core. Decode reads operands and reserves destinations through it. Writeback retires results, and optional write-to-read bypass is built in. It generalises the single-cycle core's 2R/1W file in data width, register count, read ports, write ports and forwarding mode.

## Interface
- XLEN, 32: register data width in bits.
- NREGS, 32: number of architectural registers; power of two, ≥ 2; AW = $clog2(NREGS).
- NRP, 2: number of read ports.
- NWP, 1: number of write ports (1–4).
- BYPASS, 1: 1 = same-cycle write data forwarded to reads; 0 = reads see the array only.
- Clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all registers and all busy bits.
- AddrR  in  NRP*AW  read addresses; port i occupies bits [i*AW +: AW].
- DataR  out  NRP*XLEN  read data per port.
- BusyR  out  NRP  busy bit of the register addressed by each read port.
- WEn  in  NWP  write enables.
- AddrW  in  NWP*AW  write addresses.
- DataW  in  NWP*XLEN  write data.
- IssueEn  in  1  reserve a destination register (set its busy bit).
- IssueAddr  in  AW  register to reserve.

## Operation
- Register 0 is hardwired. Reads return 0, BusyR reads 0, and writes or issues to address 0 are discarded.
- Write: on a rising Clk with WEn[j]=1 and AddrW[j]≠0, Reg[AddrW[j]] ← DataW[j].
- Multiple write ports to the same address in one cycle: the highest-index port wins, both for the array and for the bypass.
- Read: DataR[i] = Reg[AddrR[i]], combinational.
  - If BYPASS=1 and some WEn[j]=1 with AddrW[j]=AddrR[i]≠0, DataR[i] takes the winning port's DataW instead.
- Scoreboard: one busy bit per register, held in sub-module rf_scoreboard.
  - IssueEn with IssueAddr≠0 sets busy[IssueAddr] at the next edge.
  - Any enabled write port clears busy[AddrW[j]] at the next edge.
  - Same register issued and written in the same cycle: the set wins, so busy=1. This models a new instruction re-reserving its destination.
  - BusyR[i] = busy[AddrR[i]], combinational. It is not bypassed: a clearing write becomes visible on the cycle after the edge.
- While reset is high:
  - all Reg and busy bits are 0;
  - writes and issues are ignored;
  - DataR = 0 and BusyR = 0, with bypass masked.
- Reset asserted mid-operation: all state clears immediately, without waiting for Clk. The first write is accepted on the first Clk edge after reset falls.

## Timing
- Reset values: DataR = 0, BusyR = 0 for all ports.
- Read latency is 0 cycles (combinational from addresses).
- Write visibility:
  - BYPASS=1: the written value appears on DataR in the same cycle WEn is asserted.
  - BYPASS=0: the written value appears one cycle later.
- Issue-to-busy latency is 1 cycle. Writeback-to-not-busy latency is 1 cycle.
- There is no handshake: every enabled write and issue is accepted unconditionally each cycle.
- The longest combinational path is AddrR → bypass compare/mux → DataR. It must close at core frequency with NRP=4, NWP=2.

## Structure
- Package rf_pkg holds:
  - the default constants (XLEN_DEF, NREGS_DEF);
  - the function clog2_safe;
  - the port-slicing helper macros' widths.
- Sub-module rf_scoreboard (params NREGS, NWP) holds the busy vector, the set/clear priority logic and its asynchronous reset.
- The top level holds the storage array, the per-port read/bypass mux and the write-port priority resolve.

## Test plan
- Reset: assert reset asynchronously mid-cycle after writing Reg5=0xDEADBEEF -> DataR (AddrR=5) = 0 immediately, BusyR=0; after release, a read of 5 returns 0.
- Zero register: WEn[0]=1, AddrW=0, DataW=0xFFFFFFFF, IssueEn on address 0 -> a read of 0 returns 0 and BusyR=0, in the same cycle and the next.
- Bypass:
  - BYPASS=1: write 0x12345678 to r7 while AddrR[1]=7 -> DataR[1]=0x12345678 in the same cycle.
  - BYPASS=0: the old value is shown that cycle; 0x12345678 appears on the next cycle.
- Write-port conflict: NWP=2, both ports write r3 (0xA, 0xB) -> DataR reads 0xB via bypass and from the array afterwards.
- Scoreboard:
  - issue r9 -> BusyR=1 next cycle;
  - write r9 -> BusyR=0 the cycle after;
  - issue r9 and write r9 in the same cycle -> BusyR stays 1.
- Parameter sweep: XLEN=64, NREGS=16, NRP=4 random read/write/issue traffic versus a reference model -> zero mismatches over 10k cycles.
